// File: rtl/baud_pkg.sv
// baud_pkg: shared defaults, minimum divisor and divisor record for the baud generator
package baud_pkg;
  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DEFAULT_DIV    = 651;
  localparam int MIN_DIV        = 2;
  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_i;
    logic [FRAC_W_DEF-1:0] div_f;
  } div_t;
endpackage

// File: rtl/baud_gen_prog_if.sv
// baud_gen_prog_if: CSR-side control and tick outputs of the baud generator
//   master (CSR/engines): drives en, sync_rst, div_wr, div_int, div_frac; reads div_cur, tick_os, tick_baud
//   slave  (generator)  : the reverse
interface baud_gen_prog_if #(
  parameter int DIV_W  = baud_pkg::DIV_W_DEF,
  parameter int FRAC_W = baud_pkg::FRAC_W_DEF
);
  logic              en;
  logic              sync_rst;
  logic              div_wr;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [DIV_W-1:0]  div_cur;
  logic              tick_os;
  logic              tick_baud;
  modport master(output en, sync_rst, div_wr, div_int, div_frac,
                 input  div_cur, tick_os, tick_baud);
  modport slave (input  en, sync_rst, div_wr, div_int, div_frac,
                 output div_cur, tick_os, tick_baud);
endinterface

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional phase accumulator; o_long flags that the current period is one clk longer
//   clk, reset : clock, async active-high reset
//   i_clr      : synchronous clear (phase restart)
//   i_step     : period wrap, add i_frac to the accumulator
//   i_frac     : fraction applying to the period that follows the wrap
//   o_long     : carry of the last step, i.e. the running period is div_cur+1
module baud_frac_acc #(
  parameter int FRAC_W = baud_pkg::FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_long
);
  logic [FRAC_W-1:0] r_acc;
  logic              r_long;
  always_ff @(posedge clk or posedge reset)
    if (reset) {r_long, r_acc} <= '0;
    else if (i_clr) {r_long, r_acc} <= '0;
    else if (i_step) {r_long, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
  assign o_long = r_long;
endmodule

// File: rtl/baud_gen_prog.sv
// baud_gen_prog: programmable UART baud generator producing oversample and bit ticks
//   clk, reset : clock, async active-high reset
//   bus (slave): en, sync_rst, div_wr, div_int, div_frac in; div_cur, tick_os, tick_baud out
//   BAUD_FRAC_EN defined enables the fractional divisor (div_frac), otherwise div_frac is ignored
module baud_gen_prog #(
  parameter int DIV_W       = baud_pkg::DIV_W_DEF,
  parameter int FRAC_W      = baud_pkg::FRAC_W_DEF,
  parameter int OVERSAMPLE  = baud_pkg::OVERSAMPLE_DEF,
  parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV
) (
  input logic             clk,
  input logic             reset,
  baud_gen_prog_if.slave  bus
);
  localparam int OS_W = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  logic [DIV_W-1:0] r_cnt, r_div_cur, r_sh_int, w_wr_int, w_nxt_int;
  logic [OS_W-1:0]  r_os_cnt;
  logic r_pend, r_tick_os, r_tick_baud, w_long, w_run, w_last, w_wrap, w_swap, w_os_last;
  assign w_wr_int  = bus.div_int < DIV_W'(baud_pkg::MIN_DIV) ? DIV_W'(baud_pkg::MIN_DIV) : bus.div_int;
  assign w_nxt_int = bus.div_wr ? w_wr_int : r_sh_int;
  assign w_run     = bus.en & ~bus.sync_rst;
  // >= rather than == so an immediate load of a smaller divisor mid-period still wraps
  assign w_last    = {1'b0, r_cnt} + (DIV_W+1)'(1) >= {1'b0, r_div_cur} + (DIV_W+1)'(w_long);
  assign w_wrap    = w_run & w_last;
  // a pending (or same-cycle) write takes over exactly at the period boundary
  assign w_swap    = w_wrap & (r_pend | bus.div_wr);
  assign w_os_last = r_os_cnt == OS_W'(OVERSAMPLE-1);
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_frac, r_sh_frac, w_nxt_frac;
  assign w_nxt_frac = bus.div_wr ? bus.div_frac : r_sh_frac;
  baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (bus.sync_rst),
    .i_step (w_wrap),
    .i_frac (w_swap ? w_nxt_frac : r_frac),
    .o_long (w_long)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_frac    <= '0;
      r_sh_frac <= '0;
    end else begin
      if (bus.div_wr & ~w_run) r_frac <= bus.div_frac;
      else if (w_swap) r_frac <= w_nxt_frac;
      if (bus.div_wr) r_sh_frac <= bus.div_frac;
    end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^bus.div_frac;
  assign w_long = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt       <= '0;
      r_os_cnt    <= '0;
      r_div_cur   <= DIV_W'(DEFAULT_DIV);
      r_sh_int    <= DIV_W'(DEFAULT_DIV);
      r_pend      <= 1'b0;
      r_tick_os   <= 1'b0;
      r_tick_baud <= 1'b0;
    end else begin
      r_tick_os   <= w_wrap;
      r_tick_baud <= w_wrap & w_os_last;
      if (bus.sync_rst) begin
        r_cnt    <= '0;
        r_os_cnt <= '0;
      end else if (bus.en) begin
        r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
        if (w_last) r_os_cnt <= w_os_last ? '0 : r_os_cnt + OS_W'(1);
      end
      if (bus.div_wr & ~w_run) begin
        r_div_cur <= w_wr_int;
        r_pend    <= 1'b0;
      end else if (w_swap) begin
        r_div_cur <= w_nxt_int;
        r_pend    <= 1'b0;
      end else if (bus.div_wr) r_pend <= 1'b1;
      if (bus.div_wr) r_sh_int <= w_wr_int;
    end
  assign bus.div_cur   = r_div_cur;
  assign bus.tick_os   = r_tick_os;
  assign bus.tick_baud = r_tick_baud;
endmodule

// File: tb/tb_baud_gen_prog.sv
// tb_baud_gen_prog: directed stimulus, per-cycle reference model compare plus literal timing checks
module tb_baud_gen_prog;
  import baud_pkg::*;
  localparam int OS = 16;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif
  logic clk, reset;
  int cyc = 0, checks = 0, errors = 0;
  bit started = 0;
  baud_gen_prog_if #(.DIV_W(16), .FRAC_W(4)) bus ();
  baud_gen_prog #(.DIV_W(16), .FRAC_W(4), .OVERSAMPLE(OS), .DEFAULT_DIV(651)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // reference model: elapsed en-cycles per period, fraction as an unbounded running sum
  int m_div, m_frac, m_sh_div, m_sh_frac, m_el, m_extra, m_fsum, m_n;
  bit m_pend, m_os, m_baud;
  always @(posedge clk or posedge reset) begin
    int wv, old;
    if (reset) begin
      m_div = 651; m_frac = 0; m_sh_div = 651; m_sh_frac = 0; m_pend = 0;
      m_el = 0; m_extra = 0; m_fsum = 0; m_n = 0; m_os = 0; m_baud = 0;
    end else begin
      wv = bus.div_int < 2 ? 2 : int'(bus.div_int);
      m_os = 0; m_baud = 0;
      if (bus.div_wr && (!bus.en || bus.sync_rst)) begin
        m_div = wv; m_frac = int'(bus.div_frac); m_pend = 0;
      end
      if (bus.sync_rst) begin
        m_el = 0; m_fsum = 0; m_extra = 0; m_n = 0;
      end else if (bus.en) begin
        m_el++;
        if (m_el >= m_div + m_extra) begin
          m_el = 0; m_os = 1; m_n++;
          if (m_n == OS) begin m_baud = 1; m_n = 0; end
          if (bus.div_wr) begin m_div = wv; m_frac = int'(bus.div_frac); m_pend = 0; end
          else if (m_pend) begin m_div = m_sh_div; m_frac = m_sh_frac; m_pend = 0; end
          old = m_fsum;
          m_fsum += m_frac;
          m_extra = (FRAC && (m_fsum / 16 != old / 16)) ? 1 : 0;
        end else if (bus.div_wr) begin
          m_sh_div = wv; m_sh_frac = int'(bus.div_frac); m_pend = 1;
        end
      end
    end
  end

  always @(negedge clk) if (started) begin
    checks++;
    if (bus.tick_os !== m_os || bus.tick_baud !== m_baud || int'(bus.div_cur) != m_div) begin
      errors++;
      $display("FAIL model cyc=%0d: os=%b baud=%b div_cur=%0d, expected os=%b baud=%b div_cur=%0d",
               cyc, bus.tick_os, bus.tick_baud, bus.div_cur, m_os, m_baud, m_div);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input bit baud, input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (baud ? bus.tick_baud : bus.tick_os) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL wait_%s: no tick within %0d cycles", baud ? "baud" : "os", lim);
    end
  endtask

  // load a divisor immediately and restart the phase (en low, sync_rst high)
  task automatic load_restart(input div_t d);
    bus.en = 0; bus.sync_rst = 1; bus.div_wr = 1;
    bus.div_int = d.div_i; bus.div_frac = d.div_f;
    @(negedge clk);
    bus.sync_rst = 0; bus.div_wr = 0;
  endtask

  int t, t2, t0, n;
  initial begin
    reset = 1; bus.en = 0; bus.sync_rst = 0; bus.div_wr = 0; bus.div_int = 0; bus.div_frac = 0;
    @(negedge clk); started = 1;
    repeat (2) @(negedge clk);
    check("rst_div_cur", int'(bus.div_cur), 651);
    check("rst_tick_os", int'(bus.tick_os), 0);
    #2 reset = 0;
    // 1: int=4 -> tick every 4, baud every 64
    @(negedge clk);
    bus.div_wr = 1; bus.div_int = 4; bus.div_frac = 0;
    @(negedge clk); bus.div_wr = 0;
    check("t1_div_cur", int'(bus.div_cur), 4);
    bus.en = 1; t0 = cyc;
    wait_tick(0, 20, t);  check("t1_first_os", t - t0, 4);
    wait_tick(0, 20, t2); check("t1_os_gap", t2 - t, 4);
    wait_tick(1, 200, t); check("t1_first_baud", t - t0, 64);
    wait_tick(1, 200, t2); check("t1_baud_gap", t2 - t, 64);
    // 2: int=4 frac=8 -> 16 periods span 72 (fractional) or 64 clk
    load_restart('{div_i: 16'd4, div_f: 4'd8});
    bus.en = 1; t0 = cyc;
    wait_tick(0, 20, t); check("t2_first_os", t - t0, 4);
    t2 = t;
    for (int i = 0; i < 16; i++) wait_tick(0, 20, t2);
    check("t2_16_periods", t2 - t, FRAC ? 72 : 64);
    // 3: int=10, write 5 at cnt=3 -> this period 10, next 5
    load_restart('{div_i: 16'd10, div_f: 4'd0});
    bus.en = 1; t0 = cyc;
    repeat (3) @(negedge clk);
    bus.div_wr = 1; bus.div_int = 5;
    @(negedge clk); bus.div_wr = 0;
    check("t3_div_held", int'(bus.div_cur), 10);
    wait_tick(0, 30, t);  check("t3_period_10", t - t0, 10);
    check("t3_div_at_boundary", int'(bus.div_cur), 5);
    wait_tick(0, 30, t2); check("t3_period_5", t2 - t, 5);
    // 4: divisors 0 and 1 clamp to 2
    load_restart('{div_i: 16'd0, div_f: 4'd0});
    check("t4_clamp0", int'(bus.div_cur), 2);
    bus.div_wr = 1; bus.div_int = 1;
    @(negedge clk); bus.div_wr = 0;
    check("t4_clamp1", int'(bus.div_cur), 2);
    bus.en = 1; t0 = cyc;
    wait_tick(0, 10, t);  check("t4_first_os", t - t0, 2);
    wait_tick(0, 10, t2); check("t4_os_gap", t2 - t, 2);
    // 5: int=6, en low 7 clk at cnt=2, then sync_rst at cnt=3
    load_restart('{div_i: 16'd6, div_f: 4'd0});
    bus.en = 1;
    repeat (2) @(negedge clk);
    bus.en = 0; n = 0;
    repeat (7) begin @(negedge clk); n += int'(bus.tick_os); end
    check("t5_no_tick_idle", n, 0);
    bus.en = 1; t0 = cyc;
    wait_tick(0, 20, t); check("t5_resume", t - t0, 4);
    repeat (3) @(negedge clk);
    bus.sync_rst = 1;
    @(negedge clk); bus.sync_rst = 0;
    check("t5_sync_tick", int'(bus.tick_os), 0);
    t0 = cyc;
    wait_tick(0, 20, t); check("t5_after_sync", t - t0, 6);
    // 6: async reset mid-period and mid-baud
    for (int i = 0; i < 5; i++) wait_tick(0, 20, t);
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1 check("t6_rst_os", int'(bus.tick_os), 0);
    check("t6_rst_baud", int'(bus.tick_baud), 0);
    check("t6_rst_div", int'(bus.div_cur), 651);
    @(negedge clk);
    #2 reset = 0; t0 = cyc;
    wait_tick(0, 1000, t);    check("t6_first_os", t - t0, 651);
    wait_tick(1, 11000, t2);  check("t6_first_baud", t2 - t0, 651 * 16);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
